// File: rtl/led_debug_sel_ctrl.sv
// rtl/led_debug_sel_ctrl.sv - button-stepped / auto-scanned channel select for the LED debug mux
//
// Purpose: synchronizes and debounces three active-low push-buttons and uses
// them to step a channel index up/down, or to toggle an auto-scan mode that
// advances the channel every C_DWELL_CYCLES cycles.
//
// Ports:
//   CLK         - single clock, rising edge
//   RST_N       - asynchronous assert, active-low reset
//   BTN_UP_N    - raw UP button, active-low, asynchronous
//   BTN_DOWN_N  - raw DOWN button, active-low, asynchronous
//   BTN_MODE_N  - raw MODE button, active-low, asynchronous
//   SELECTOR    - active-low encoded channel (~sel) for the mux
//   CUR_SEL     - true-encoded current channel
//   AUTO_MODE   - 1 while auto-scanning

module led_debug_sel_ctrl #(
  parameter int C_NUM_INPUTS      = 16,
  parameter int C_DEBOUNCE_CYCLES = 1000000,
  parameter int C_DWELL_CYCLES    = 100000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_UP_N,
  input  logic       BTN_DOWN_N,
  input  logic       BTN_MODE_N,
  output logic [3:0] SELECTOR,
  output logic [3:0] CUR_SEL,
  output logic       AUTO_MODE
);

  localparam int DBW = $clog2(C_DEBOUNCE_CYCLES);
  localparam int DWW = $clog2(C_DWELL_CYCLES);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(C_DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(C_DWELL_CYCLES - 1);
  localparam logic [3:0]     SEL_LAST   = 4'(C_NUM_INPUTS - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

  // Button index: 0 = UP, 1 = DOWN, 2 = MODE
  logic [2:0] btn_n;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [1:0] valid_q;
  logic [2:0] press;

  assign btn_n = {BTN_MODE_N, BTN_DOWN_N, BTN_UP_N};

  // valid_q[1] marks the cycles where sync2_q carries a real post-reset
  // sample instead of the forced "released" reset value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      valid_q <= 2'b00;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      valid_q <= {valid_q[0], 1'b1};
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_debounce
    logic [DBW-1:0] cnt_q;
    logic           db_q;
    logic           armed_q;
    logic           press_q;

    // armed_q keeps a button held through reset release from producing a
    // press: it must first be seen released after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q   <= '0;
        db_q    <= 1'b1;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (valid_q[1] && sync2_q[b]) begin
          armed_q <= 1'b1;
        end
        if (sync2_q[b] == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q   <= '0;
          db_q    <= sync2_q[b];
          press_q <= ~sync2_q[b] & armed_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[b] = press_q;
  end

  state_e         state_q, state_d;
  logic [3:0]     sel_q, sel_d;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic           up_step, dn_step, any_press, keep_auto, expire;
  logic [3:0]     sel_inc, sel_dec;

  assign up_step   = press[0] & ~press[1];
  assign dn_step   = press[1] & ~press[0];
  assign any_press = press[0] | press[1];
  // Dwell only runs while AUTO persists and no button event intervenes;
  // a coinciding press or mode change wins over the expiry.
  assign keep_auto = (state_q == ST_AUTO) && !press[2] && !any_press;
  assign expire    = keep_auto && (dwell_q == DWELL_LAST);
  assign sel_inc   = (sel_q == SEL_LAST) ? 4'd0 : sel_q + 4'd1;
  assign sel_dec   = (sel_q == 4'd0) ? SEL_LAST : sel_q - 4'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_MANUAL;
      sel_q   <= 4'd0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = '0;
    if (press[2]) begin
      state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
    end
    if (up_step || expire) begin
      sel_d = sel_inc;
    end else if (dn_step) begin
      sel_d = sel_dec;
    end
    if (keep_auto && !expire) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  assign CUR_SEL   = sel_q;
  assign SELECTOR  = ~sel_q;
  assign AUTO_MODE = (state_q == ST_AUTO);

endmodule
